// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin arbiter sharing one FIFO enqueue port, with burst lock and stall watchdog
`ifndef PATH_WIDTH
`define PATH_WIDTH 8
`endif
module fifo_enq_arbiter #(
    parameter int PATH_WIDTH = `PATH_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2,
    parameter int HOLD_MAX   = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*PATH_WIDTH-1:0] d_req,
    output logic [NUM_REQ-1:0]            ack,
    output logic [PATH_WIDTH-1:0]         fifo_d_in,
    output logic                          fifo_enq,
    input  logic                          fifo_busy,
    output logic [IDX_W-1:0]              owner,
    output logic                          locked,
    output logic                          timeout_err
);
    localparam int HC_W = $clog2(HOLD_MAX + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;
    logic [IDX_W-1:0] ptr, rr_sel, sel, cand;
    logic [HC_W-1:0] hold_cnt;
    logic rr_found, valid, take, done, owner_req;
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction
    always_comb begin
        rr_found = 1'b0;
        rr_sel = ptr;
        cand = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_sel = cand;
            end
        end
    end
    // Outputs are gated by reset so an asserted reset silences the FIFO port at once.
    always_comb begin
        owner_req = req[owner];
        valid = (state == BURST) ? owner_req : rr_found;
        sel = (state == BURST) ? owner : rr_sel;
        fifo_enq = rst && valid;
        take = fifo_enq && !fifo_busy;
        ack = take ? (NUM_REQ'(1) << sel) : '0;
        fifo_d_in = valid ? d_req[int'(sel)*PATH_WIDTH +: PATH_WIDTH] : '0;
        done = take && last[sel];
        timeout_err = rst && (state == BURST) && !owner_req && (hold_cnt == HC_W'(HOLD_MAX));
        locked = (state == BURST);
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (take && !last[sel]) ? BURST : IDLE;
        else
            state_nxt = (done || timeout_err) ? IDLE : BURST;
    end
    // Backpressure on a requesting owner freezes hold_cnt; only owner silence counts as a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (take && state == IDLE)
                owner <= sel;
            if (done || timeout_err)
                ptr <= wrap_inc(sel);
            hold_cnt <= (take || timeout_err) ? '0 :
                        (state == BURST && !owner_req) ? hold_cnt + 1'b1 : hold_cnt;
        end
    end
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb_fifo_enq_arbiter: directed and random checks of the round-robin FIFO enqueue arbiter
module tb_fifo_enq_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int HM = 15;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] last = '0;
    logic [N*W-1:0] d_req = '0;
    logic fifo_busy = 1'b0;
    logic [N-1:0] ack;
    logic [W-1:0] fifo_d_in;
    logic fifo_enq;
    logic [1:0] owner;
    logic locked;
    logic timeout_err;
    int total = 0;
    int bad = 0;

    fifo_enq_arbiter #(.PATH_WIDTH(W), .NUM_REQ(N), .IDX_W(2), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .d_req(d_req), .ack(ack),
        .fifo_d_in(fifo_d_in), .fifo_enq(fifo_enq), .fifo_busy(fifo_busy),
        .owner(owner), .locked(locked), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        last = '0;
        fifo_busy = 1'b0;
        d_req = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [N-1:0] seq_exp [5];
        logic [W-1:0] d_exp [5];
        seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        @(negedge clk);
        rst = 1'b0;
        req = '1;
        last = '1;
        fifo_busy = 1'b0;
        d_req = 32'h44332211;
        @(posedge clk); #1;
        total++; if ({owner, locked, timeout_err} !== 4'b0) begin bad++; $display("FAIL reset_regs owner=%0d locked=%b to=%b exp 0", owner, locked, timeout_err); end
        total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr ptr=%0d exp 0", dut.ptr); end
        total++; if (ack !== 4'b0 || fifo_enq !== 1'b0) begin bad++; $display("FAIL reset_ack ack=%b enq=%b exp 0", ack, fifo_enq); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (ack !== seq_exp[k]) begin bad++; $display("FAIL reset_rr[%0d] ack=%b exp=%b", k, ack, seq_exp[k]); end
            total++; if (fifo_d_in !== d_exp[k]) begin bad++; $display("FAIL reset_rr_data[%0d] d=%h exp=%h", k, fifo_d_in, d_exp[k]); end
            @(negedge clk);
        end
        req = '0;
        last = '0;
    endtask

    task automatic test_burst_lock();
        do_reset();
        req = 4'b0101;
        last = 4'b0000;
        d_req[0*W +: W] = 8'hA0;
        d_req[2*W +: W] = 8'hC0;
        #1;
        total++; if (ack !== 4'b0001 || locked !== 1'b0) begin bad++; $display("FAIL burst_w1 ack=%b locked=%b exp 0001/0", ack, locked); end
        @(posedge clk); #1;
        total++; if (locked !== 1'b1 || owner !== 2'd0) begin bad++; $display("FAIL burst_lock locked=%b owner=%0d exp 1/0", locked, owner); end
        @(negedge clk);
        d_req[0*W +: W] = 8'hA1;
        #1;
        total++; if (ack !== 4'b0001 || fifo_d_in !== 8'hA1) begin bad++; $display("FAIL burst_w2 ack=%b d=%h exp 0001/a1", ack, fifo_d_in); end
        @(negedge clk);
        d_req[0*W +: W] = 8'hA2;
        last = 4'b0101;
        #1;
        total++; if (ack !== 4'b0001 || fifo_d_in !== 8'hA2) begin bad++; $display("FAIL burst_w3 ack=%b d=%h exp 0001/a2", ack, fifo_d_in); end
        @(posedge clk); #1;
        total++; if (locked !== 1'b0 || dut.ptr !== 2'd1) begin bad++; $display("FAIL burst_end locked=%b ptr=%0d exp 0/1", locked, dut.ptr); end
        @(negedge clk);
        req = 4'b0100;
        #1;
        total++; if (ack !== 4'b0100 || fifo_d_in !== 8'hC0) begin bad++; $display("FAIL burst_next ack=%b d=%h exp 0100/c0", ack, fifo_d_in); end
        @(posedge clk); #1;
        total++; if (dut.ptr !== 2'd3 || owner !== 2'd2 || locked !== 1'b0) begin bad++; $display("FAIL burst_ptr ptr=%0d owner=%0d locked=%b exp 3/2/0", dut.ptr, owner, locked); end
        @(negedge clk);
        req = '0;
        last = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010;
        last = 4'b0000;
        d_req[1*W +: W] = 8'hB0;
        d_req[3*W +: W] = 8'hD0;
        #1;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL bp_first ack=%b exp 0010", ack); end
        @(negedge clk);
        d_req[1*W +: W] = 8'hB1;
        fifo_busy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (ack !== 4'b0 || fifo_enq !== 1'b1 || fifo_d_in !== 8'hB1) begin bad++; $display("FAIL bp_stall[%0d] ack=%b enq=%b d=%h exp 0000/1/b1", k, ack, fifo_enq, fifo_d_in); end
            total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL bp_to[%0d] to=%b exp 0", k, timeout_err); end
            @(posedge clk); #1;
            total++; if (dut.hold_cnt !== 4'd0 || locked !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] hold=%0d locked=%b exp 0/1", k, dut.hold_cnt, locked); end
            @(negedge clk);
        end
        fifo_busy = 1'b0;
        last = 4'b0010;
        #1;
        total++; if (ack !== 4'b0010 || fifo_d_in !== 8'hB1) begin bad++; $display("FAIL bp_resume ack=%b d=%h exp 0010/b1", ack, fifo_d_in); end
        @(posedge clk); #1;
        total++; if (locked !== 1'b0 || dut.ptr !== 2'd2) begin bad++; $display("FAIL bp_end locked=%b ptr=%0d exp 0/2", locked, dut.ptr); end
        @(negedge clk);
        req = 4'b1010;
        last = 4'b1010;
        fifo_busy = 1'b1;
        #1;
        total++; if (ack !== 4'b0 || fifo_enq !== 1'b1 || fifo_d_in !== 8'hD0) begin bad++; $display("FAIL idle_busy ack=%b enq=%b d=%h exp 0000/1/d0", ack, fifo_enq, fifo_d_in); end
        @(posedge clk); #1;
        total++; if (dut.ptr !== 2'd2 || owner !== 2'd1) begin bad++; $display("FAIL idle_busy_hold ptr=%0d owner=%0d exp 2/1", dut.ptr, owner); end
        @(negedge clk);
        req = 4'b0010;
        fifo_busy = 1'b0;
        #1;
        total++; if (ack !== 4'b0010 || fifo_d_in !== 8'hB1) begin bad++; $display("FAIL regrant ack=%b d=%h exp 0010/b1", ack, fifo_d_in); end
        @(negedge clk);
        req = '0;
        last = '0;
    endtask

    task automatic test_timeout();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        do_reset();
        req = 4'b1000;
        last = 4'b0000;
        #1;
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL to_start ack=%b exp 1000", ack); end
        @(negedge clk);
        req = '0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            if (timeout_err === 1'b1) begin pulses++; at = k; end
            if (k == 16) begin
                total++; if (dut.hold_cnt !== 4'd15 || locked !== 1'b1) begin bad++; $display("FAIL to_cnt hold=%0d locked=%b exp 15/1", dut.hold_cnt, locked); end
            end
            @(negedge clk);
        end
        total++; if (locked !== 1'b0 || dut.ptr !== 2'd0) begin bad++; $display("FAIL to_after locked=%b ptr=%0d exp 0/0", locked, dut.ptr); end
        for (int k = 0; k < 3; k++) begin
            #1;
            if (timeout_err === 1'b1) pulses++;
            @(negedge clk);
        end
        total++; if (pulses !== 1 || at !== 16) begin bad++; $display("FAIL to_pulse count=%0d at=%0d exp 1/16", pulses, at); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0010;
        last = 4'b0000;
        @(posedge clk); #1;
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL mr_lock locked=%b exp 1", locked); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (locked !== 1'b0 || ack !== 4'b0 || fifo_enq !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL mr_async locked=%b ack=%b enq=%b to=%b exp 0", locked, ack, fifo_enq, timeout_err); end
        @(negedge clk);
        rst = 1'b1;
        req = '1;
        last = '1;
        #1;
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL mr_restart ack=%b exp 0001", ack); end
        @(negedge clk);
        req = '0;
        last = '0;
    endtask

    task automatic test_random_soak();
        logic [N-1:0] pend;
        logic [N-1:0] plast;
        logic [N-1:0] exp_ack;
        logic [W-1:0] fifo_q [$];
        logic [W-1:0] w;
        int seqn [N];
        int waitc [N];
        int rcv [N];
        int m_ptr, m_own, m_idle, sel, g, n_acks;
        bit m_lock, found, exp_to, exp_enq;
        pend = '0;
        plast = '0;
        m_ptr = 0; m_own = 0; m_idle = 0; m_lock = 0; n_acks = 0;
        for (int i = 0; i < N; i++) begin seqn[i] = 0; waitc[i] = 0; rcv[i] = 0; end
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    plast[i] = 1'($urandom_range(0, 1));
                end
                d_req[i*W +: W] = {2'(i), 6'(seqn[i])};
            end
            req = pend;
            last = plast;
            fifo_busy = ($urandom_range(0, 3) == 0);
            #1;
            exp_ack = '0;
            exp_to = 0;
            found = 0;
            sel = 0;
            if (m_lock) begin
                exp_enq = req[m_own];
                if (req[m_own] && !fifo_busy) exp_ack[m_own] = 1'b1;
                exp_to = !req[m_own] && (m_idle == HM);
            end else begin
                for (int k = 0; k < N; k++)
                    if (!found && req[(m_ptr + k) % N]) begin found = 1; sel = (m_ptr + k) % N; end
                exp_enq = found;
                if (found && !fifo_busy) exp_ack[sel] = 1'b1;
            end
            total++; if (ack !== exp_ack) begin bad++; $display("FAIL soak_ack cyc=%0d ack=%b exp=%b", cyc, ack, exp_ack); end
            total++; if (fifo_busy && ack !== 4'b0) begin bad++; $display("FAIL soak_busy_ack cyc=%0d ack=%b exp 0000", cyc, ack); end
            total++; if (fifo_enq !== exp_enq) begin bad++; $display("FAIL soak_enq cyc=%0d enq=%b exp=%b", cyc, fifo_enq, exp_enq); end
            total++; if (timeout_err !== exp_to || locked !== m_lock) begin bad++; $display("FAIL soak_state cyc=%0d to=%b locked=%b exp %b/%b", cyc, timeout_err, locked, exp_to, m_lock); end
            if (fifo_enq === 1'b1 && fifo_busy === 1'b0) fifo_q.push_back(fifo_d_in);
            if (exp_ack != '0) begin
                g = m_lock ? m_own : sel;
                total++; if (fifo_d_in !== {2'(g), 6'(seqn[g])}) begin bad++; $display("FAIL soak_data cyc=%0d d=%h exp=%h", cyc, fifo_d_in, {2'(g), 6'(seqn[g])}); end
                if (!m_lock)
                    for (int i = 0; i < N; i++)
                        if (i != g && pend[i]) begin
                            waitc[i]++;
                            total++; if (waitc[i] > N) begin bad++; $display("FAIL soak_starve cyc=%0d req=%0d waited=%0d max=%0d", cyc, i, waitc[i], N); end
                        end
                waitc[g] = 0;
                seqn[g]++;
                n_acks++;
                pend[g] = 1'b0;
                if (!m_lock) begin
                    if (last[g]) m_ptr = (g + 1) % N;
                    else begin m_lock = 1; m_own = g; m_idle = 0; end
                end else if (last[g]) begin
                    m_lock = 0;
                    m_ptr = (m_own + 1) % N;
                end else m_idle = 0;
            end else if (m_lock) begin
                if (exp_to) begin m_lock = 0; m_ptr = (m_own + 1) % N; end
                else if (!req[m_own]) m_idle++;
            end
            @(negedge clk);
        end
        req = '0;
        last = '0;
        fifo_busy = 1'b0;
        total++; if (fifo_q.size() !== n_acks) begin bad++; $display("FAIL soak_count fifo=%0d exp=%0d", fifo_q.size(), n_acks); end
        while (fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            total++; if (w[5:0] !== 6'(rcv[w[7:6]])) begin bad++; $display("FAIL soak_order req=%0d seq=%0d exp=%0d", w[7:6], w[5:0], 6'(rcv[w[7:6]])); end
            rcv[w[7:6]]++;
        end
    endtask

    initial begin
        test_reset();
        test_burst_lock();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        test_random_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
